// File: rtl/flow_director_mq_pkg.sv
// Shared packet metadata payload and flag encodings for the flow director.
package flow_director_mq_pkg;

  localparam int unsigned FLAGS_WIDTH = 8;

  localparam logic [FLAGS_WIDTH-1:0] PKT_PCIE = 8'h01;
  localparam logic [FLAGS_WIDTH-1:0] PKT_DROP = 8'h02;

  typedef struct packed {
    logic [31:0]            pkt_hash;
    logic [31:0]            pkt_queue_id;
    logic [15:0]            pkt_size;
    logic [FLAGS_WIDTH-1:0] pkt_flags;
  } metadata_t;

endpackage

// File: rtl/flow_director_mq.sv
// Fallback queue resolution for flow-table misses: per-group hash or round-robin
// steering, registered output with a one-entry skid buffer, drop/fallback stats.
module flow_director_mq
  import flow_director_mq_pkg::*;
#(
  parameter int unsigned NB_GROUPS      = 4,
  parameter int unsigned QUEUE_ID_WIDTH = 32,
  parameter int unsigned GROUP_WIDTH    = (NB_GROUPS > 1) ? $clog2(NB_GROUPS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  metadata_t                 in_meta_data,
  input  logic [GROUP_WIDTH-1:0]    in_group,
  input  logic                      in_meta_valid,
  output logic                      in_meta_ready,
  output metadata_t                 out_meta_data,
  output logic                      out_meta_valid,
  input  logic                      out_meta_ready,
  input  logic [GROUP_WIDTH-1:0]    conf_group,
  input  logic [31:0]               conf_nb_queues,
  input  logic [31:0]               conf_mask,
  input  logic [QUEUE_ID_WIDTH-1:0] conf_base,
  input  logic                      conf_enable_rr,
  input  logic                      conf_valid,
  output logic                      conf_ready,
  output logic [31:0]               stat_drop_cnt,
  output logic [31:0]               stat_fallback_cnt
);

  localparam int unsigned QW = QUEUE_ID_WIDTH;

  logic [31:0]   nb_q     [NB_GROUPS];
  logic [31:0]   mask_q   [NB_GROUPS];
  logic [QW-1:0] base_q   [NB_GROUPS];
  logic          rr_en_q  [NB_GROUPS];
  logic [31:0]   rr_ptr_q [NB_GROUPS];

  metadata_t     res_data;
  logic [QW-1:0] res_qid;
  logic          unmatched;
  logic          is_drop;
  logic          is_fallback;
  logic          accept;

  metadata_t     skid_data;
  logic          skid_valid;

  assign conf_ready = 1'b1;
  assign accept     = in_meta_valid & in_meta_ready;
  assign unmatched  = &in_meta_data.pkt_queue_id;

  // Destination resolution for the packet currently presented on the input.
  always_comb begin
    res_data           = in_meta_data;
    res_data.pkt_flags = PKT_PCIE;
    res_qid            = '0;
    is_drop            = 1'b0;
    is_fallback        = 1'b0;
    if (unmatched) begin
      if (nb_q[in_group] == 32'd0) begin
        is_drop            = 1'b1;
        res_data.pkt_flags = PKT_DROP;
      end else begin
        is_fallback = 1'b1;
        if (rr_en_q[in_group]) begin
          res_qid = base_q[in_group] + QW'(rr_ptr_q[in_group]);
        end else begin
          res_qid = base_q[in_group] +
                    (QW'(in_meta_data.pkt_hash) & QW'(mask_q[in_group]));
        end
        res_data.pkt_queue_id = 32'(res_qid);
      end
    end
  end

  // Output register backed by a skid entry; in_meta_ready mirrors skid emptiness.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_meta_valid <= 1'b0;
      out_meta_data  <= '0;
      skid_valid     <= 1'b0;
      skid_data      <= '0;
      in_meta_ready  <= 1'b0;
    end else begin
      if (!out_meta_valid || out_meta_ready) begin
        in_meta_ready <= 1'b1;
        if (skid_valid) begin
          out_meta_valid <= 1'b1;
          out_meta_data  <= skid_data;
          skid_valid     <= 1'b0;
        end else begin
          out_meta_valid <= accept;
          if (accept) begin
            out_meta_data <= res_data;
          end
        end
      end else if (accept) begin
        skid_valid    <= 1'b1;
        skid_data     <= res_data;
        in_meta_ready <= 1'b0;
      end
    end
  end

  // Group configuration, round-robin pointers and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NB_GROUPS; i++) begin
        nb_q[i]     <= '0;
        mask_q[i]   <= '0;
        base_q[i]   <= '0;
        rr_en_q[i]  <= 1'b0;
        rr_ptr_q[i] <= '0;
      end
      stat_drop_cnt     <= '0;
      stat_fallback_cnt <= '0;
    end else begin
      if (accept && is_drop) begin
        stat_drop_cnt <= stat_drop_cnt + 32'd1;
      end
      if (accept && is_fallback) begin
        stat_fallback_cnt <= stat_fallback_cnt + 32'd1;
        if (rr_en_q[in_group]) begin
          rr_ptr_q[in_group] <= (rr_ptr_q[in_group] + 32'd1) & mask_q[in_group];
        end
      end
      // Placed last so a same-cycle write to the advancing group wins.
      if (conf_valid) begin
        nb_q[conf_group]     <= conf_nb_queues;
        mask_q[conf_group]   <= conf_mask;
        base_q[conf_group]   <= conf_base;
        rr_en_q[conf_group]  <= conf_enable_rr;
        rr_ptr_q[conf_group] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_flow_director_mq.sv
// Randomized and directed bench for flow_director_mq against a queue-based reference model.
module tb_flow_director_mq;
  import flow_director_mq_pkg::*;

  logic        clk;
  logic        rst;
  metadata_t   in_meta_data;
  logic [1:0]  in_group;
  logic        in_meta_valid;
  logic        in_meta_ready;
  metadata_t   out_meta_data;
  logic        out_meta_valid;
  logic        out_meta_ready;
  logic [1:0]  conf_group;
  logic [31:0] conf_nb_queues;
  logic [31:0] conf_mask;
  logic [31:0] conf_base;
  logic        conf_enable_rr;
  logic        conf_valid;
  logic        conf_ready;
  logic [31:0] stat_drop_cnt;
  logic [31:0] stat_fallback_cnt;

  flow_director_mq #(.NB_GROUPS(4), .QUEUE_ID_WIDTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_meta_data      (in_meta_data),
    .in_group          (in_group),
    .in_meta_valid     (in_meta_valid),
    .in_meta_ready     (in_meta_ready),
    .out_meta_data     (out_meta_data),
    .out_meta_valid    (out_meta_valid),
    .out_meta_ready    (out_meta_ready),
    .conf_group        (conf_group),
    .conf_nb_queues    (conf_nb_queues),
    .conf_mask         (conf_mask),
    .conf_base         (conf_base),
    .conf_enable_rr    (conf_enable_rr),
    .conf_valid        (conf_valid),
    .conf_ready        (conf_ready),
    .stat_drop_cnt     (stat_drop_cnt),
    .stat_fallback_cnt (stat_fallback_cnt)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: per-group config and a count of RR packets since the last write.
  int unsigned m_nb[4];
  int unsigned m_mask[4];
  int unsigned m_base[4];
  bit          m_rr[4];
  int unsigned m_cnt[4];
  int unsigned m_drop;
  int unsigned m_fb;
  metadata_t   exp_q[$];
  metadata_t   rx_q[$];

  int  rdy_mode = 0;
  int  pat_i    = 0;
  int  cyc      = 0;
  bit  bp_track = 0;
  int  stall_cyc;
  int  drop_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic metadata_t mk(input logic [31:0] qid, input logic [31:0] hash);
    metadata_t m;
    m.pkt_hash     = hash;
    m.pkt_queue_id = qid;
    m.pkt_size     = 16'($urandom);
    m.pkt_flags    = 8'($urandom);
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_nb[i] = 0; m_mask[i] = 0; m_base[i] = 0; m_rr[i] = 0; m_cnt[i] = 0;
    end
    m_drop = 0;
    m_fb   = 0;
    exp_q.delete();
  endtask

  task automatic model_conf(input int g, input int unsigned nb, input int unsigned mask,
                            input int unsigned base, input bit rr);
    m_nb[g] = nb; m_mask[g] = mask; m_base[g] = base; m_rr[g] = rr; m_cnt[g] = 0;
  endtask

  task automatic model_accept(input metadata_t m, input int g);
    metadata_t r;
    r = m;
    r.pkt_flags = PKT_PCIE;
    if (m.pkt_queue_id == 32'hFFFF_FFFF) begin
      if (m_nb[g] == 0) begin
        r.pkt_flags = PKT_DROP;
        m_drop++;
      end else if (m_rr[g]) begin
        r.pkt_queue_id = m_base[g] + (m_cnt[g] & m_mask[g]);
        m_cnt[g]++;
        m_fb++;
      end else begin
        r.pkt_queue_id = m_base[g] + (m.pkt_hash & m_mask[g]);
        m_fb++;
      end
    end
    exp_q.push_back(r);
  endtask

  // Output ready pattern generator.
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    out_meta_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        1:       begin out_meta_ready = pat[3 - (pat_i % 4)]; pat_i++; end
        2:       out_meta_ready = 1'($urandom_range(0, 1));
        3:       out_meta_ready = 1'b0;
        default: out_meta_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: ordering/content against the model, and hold-while-stalled.
  initial begin
    bit        prev_stall;
    metadata_t prev_data;
    metadata_t e;
    prev_stall = 0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          vectors++;
          if (out_meta_valid !== 1'b1 || out_meta_data !== prev_data) begin
            errors++;
            $display("FAIL hold_stable got v=%b %h want v=1 %h", out_meta_valid, out_meta_data, prev_data);
          end
        end
        if (out_meta_valid && out_meta_ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got %h want none", out_meta_data);
          end else begin
            e = exp_q.pop_front();
            if (out_meta_data !== e) begin
              errors++;
              $display("FAIL model_output got %h want %h", out_meta_data, e);
            end
          end
          rx_q.push_back(out_meta_data);
        end
        if (bp_track) begin
          if (stall_cyc < 0 && out_meta_valid && !out_meta_ready) stall_cyc = cyc;
          if (stall_cyc >= 0 && drop_cyc < 0 && !in_meta_ready) drop_cyc = cyc;
        end
        prev_stall = out_meta_valid && !out_meta_ready;
        prev_data  = out_meta_data;
      end
    end
  end

  task automatic do_conf(input int g, input int unsigned nb, input int unsigned mask,
                         input int unsigned base, input bit rr);
    conf_group = 2'(g); conf_nb_queues = nb; conf_mask = mask; conf_base = base;
    conf_enable_rr = rr; conf_valid = 1'b1;
    @(negedge clk);
    conf_valid = 1'b0;
    model_conf(g, nb, mask, base, rr);
  endtask

  task automatic send(input metadata_t m, input int g);
    int n;
    n = 0;
    in_meta_data  = m;
    in_group      = 2'(g);
    in_meta_valid = 1'b1;
    while (!in_meta_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_meta_ready) begin
      vectors++; errors++;
      $display("FAIL send_timeout got ready=0 want ready=1");
    end else begin
      model_accept(m, g);
    end
    @(negedge clk);
    in_meta_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (out_meta_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_meta_valid); end
    vectors++;
    if (in_meta_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_meta_ready); end
    vectors++;
    if (conf_ready !== 1'b1) begin errors++; $display("FAIL rst_conf_ready got %b want 1", conf_ready); end
    vectors++;
    if (stat_drop_cnt !== 32'd0 || stat_fallback_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_stats got %0d/%0d want 0/0", stat_drop_cnt, stat_fallback_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_meta_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", in_meta_ready); end
  endtask

  task automatic test_drop();
    rx_q.delete();
    do_conf(0, 0, 0, 0, 0);
    send(mk(32'hFFFF_FFFF, $urandom), 0);
    drain();
    vectors++;
    if (rx_q.size() != 1 || rx_q[0].pkt_flags !== PKT_DROP || rx_q[0].pkt_queue_id !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL drop_pkt got n=%0d %h want flags=%h qid=ffffffff", rx_q.size(), rx_q[0], PKT_DROP);
    end
    vectors++;
    if (stat_drop_cnt !== 32'd1 || stat_fallback_cnt !== 32'd0) begin
      errors++; $display("FAIL drop_stats got %0d/%0d want 1/0", stat_drop_cnt, stat_fallback_cnt);
    end
  endtask

  task automatic test_hash();
    rx_q.delete();
    do_conf(1, 4, 3, 8, 0);
    send(mk(32'hFFFF_FFFF, 32'h5), 1);
    send(mk(32'hFFFF_FFFF, 32'h6), 1);
    drain();
    vectors++;
    if (rx_q.size() != 2 || rx_q[0].pkt_queue_id !== 32'd9 || rx_q[1].pkt_queue_id !== 32'd10
        || rx_q[0].pkt_flags !== PKT_PCIE || rx_q[1].pkt_flags !== PKT_PCIE) begin
      errors++; $display("FAIL hash_qids got %0d,%0d want 9,10", rx_q[0].pkt_queue_id, rx_q[1].pkt_queue_id);
    end
    vectors++;
    if (stat_fallback_cnt !== 32'd2) begin
      errors++; $display("FAIL hash_stats got %0d want 2", stat_fallback_cnt);
    end
  endtask

  task automatic test_rr();
    int unsigned want[6];
    want = '{100, 101, 102, 103, 100, 101};
    rx_q.delete();
    do_conf(2, 4, 3, 100, 1);
    send(mk(32'hFFFF_FFFF, $urandom), 2);
    send(mk(32'hFFFF_FFFF, $urandom), 2);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) send(mk(32'hFFFF_FFFF, $urandom), 2);
    drain();
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (rx_q.size() != 6 || rx_q[i].pkt_queue_id !== want[i]) begin
        errors++; $display("FAIL rr_qid[%0d] got %0d want %0d", i, rx_q[i].pkt_queue_id, want[i]);
      end
    end
  endtask

  task automatic test_matched();
    rx_q.delete();
    send(mk(32'd7, $urandom), 2);
    send(mk(32'hFFFF_FFFF, $urandom), 2);
    drain();
    vectors++;
    if (rx_q.size() != 2 || rx_q[0].pkt_queue_id !== 32'd7 || rx_q[0].pkt_flags !== PKT_PCIE) begin
      errors++; $display("FAIL matched_pkt got qid=%0d flags=%h want 7/%h", rx_q[0].pkt_queue_id, rx_q[0].pkt_flags, PKT_PCIE);
    end
    vectors++;
    if (rx_q[1].pkt_queue_id !== 32'd102) begin
      errors++; $display("FAIL matched_no_rr_advance got %0d want 102", rx_q[1].pkt_queue_id);
    end
  endtask

  task automatic test_back_to_back();
    metadata_t sent[$];
    metadata_t m;
    rx_q.delete();
    stall_cyc = -1;
    drop_cyc  = -1;
    pat_i     = 0;
    bp_track  = 1;
    rdy_mode  = 1;
    for (int i = 0; i < 8; i++) begin
      m = mk(32'($urandom_range(0, 1000)), $urandom);
      sent.push_back(m);
      send(m, $urandom_range(0, 3));
    end
    drain();
    rdy_mode = 0;
    bp_track = 0;
    vectors++;
    if (rx_q.size() != 8) begin errors++; $display("FAIL bp_count got %0d want 8", rx_q.size()); end
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      vectors++;
      if (rx_q[i].pkt_queue_id !== sent[i].pkt_queue_id || rx_q[i].pkt_hash !== sent[i].pkt_hash) begin
        errors++; $display("FAIL bp_order[%0d] got %0d want %0d", i, rx_q[i].pkt_queue_id, sent[i].pkt_queue_id);
      end
    end
    vectors++;
    if (stall_cyc < 0 || drop_cyc != stall_cyc + 1) begin
      errors++; $display("FAIL bp_ready_drop got stall=%0d drop=%0d want drop=stall+1", stall_cyc, drop_cyc);
    end
  endtask

  task automatic test_wrap_and_conf_race();
    rx_q.delete();
    do_conf(3, 4, 3, 32'hFFFF_FFFE, 0);
    send(mk(32'hFFFF_FFFF, 32'h3), 3);
    drain();
    vectors++;
    if (rx_q.size() != 1 || rx_q[0].pkt_queue_id !== 32'd1) begin
      errors++; $display("FAIL wrap_qid got %0d want 1", rx_q[0].pkt_queue_id);
    end
    vectors++;
    if (in_meta_ready !== 1'b1) begin errors++; $display("FAIL race_ready got %b want 1", in_meta_ready); end
    in_meta_data  = mk(32'hFFFF_FFFF, $urandom);
    in_group      = 2'd2;
    in_meta_valid = 1'b1;
    conf_group = 2'd2; conf_nb_queues = 4; conf_mask = 3; conf_base = 100;
    conf_enable_rr = 1'b1; conf_valid = 1'b1;
    model_accept(in_meta_data, 2);
    @(negedge clk);
    in_meta_valid = 1'b0;
    conf_valid    = 1'b0;
    model_conf(2, 4, 3, 100, 1);
    send(mk(32'hFFFF_FFFF, $urandom), 2);
    drain();
    vectors++;
    if (rx_q.size() != 3 || rx_q[1].pkt_queue_id !== 32'd103 || rx_q[2].pkt_queue_id !== 32'd100) begin
      errors++; $display("FAIL conf_race got %0d,%0d want 103,100", rx_q[1].pkt_queue_id, rx_q[2].pkt_queue_id);
    end
  endtask

  task automatic test_random();
    int unsigned sh, nb, g;
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        sh = $urandom_range(0, 3);
        nb = ($urandom_range(0, 3) == 0) ? 0 : (32'd1 << sh);
        do_conf($urandom_range(0, 3), nb, (32'd1 << sh) - 1, $urandom, 1'($urandom_range(0, 1)));
      end else begin
        g = $urandom_range(0, 3);
        if ($urandom_range(0, 9) < 6) send(mk(32'hFFFF_FFFF, $urandom), g);
        else send(mk(32'($urandom_range(0, 32'hFFFF_FFFE)), $urandom), g);
        if ($urandom_range(0, 7) == 0) @(negedge clk);
      end
    end
    drain();
    rdy_mode = 0;
    vectors++;
    if (stat_drop_cnt !== m_drop || stat_fallback_cnt !== m_fb) begin
      errors++; $display("FAIL random_stats got %0d/%0d want %0d/%0d", stat_drop_cnt, stat_fallback_cnt, m_drop, m_fb);
    end
  endtask

  task automatic test_reset_mid();
    rx_q.delete();
    rdy_mode = 3;
    send(mk(32'hFFFF_FFFF, $urandom), 1);
    send(mk(32'd55, $urandom), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_meta_valid !== 1'b0 || in_meta_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got v=%b r=%b want 0/0", out_meta_valid, in_meta_ready);
    end
    model_reset();
    rst = 1'b0;
    rdy_mode = 0;
    repeat (5) @(negedge clk);
    vectors++;
    if (rx_q.size() != 0 || out_meta_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_discard got n=%0d v=%b want 0/0", rx_q.size(), out_meta_valid);
    end
    vectors++;
    if (stat_drop_cnt !== 32'd0 || stat_fallback_cnt !== 32'd0 || in_meta_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_state got %0d/%0d r=%b want 0/0 r=1", stat_drop_cnt, stat_fallback_cnt, in_meta_ready);
    end
  endtask

  initial begin
    rst            = 1'b1;
    in_meta_data   = '0;
    in_group       = '0;
    in_meta_valid  = 1'b0;
    conf_group     = '0;
    conf_nb_queues = '0;
    conf_mask      = '0;
    conf_base      = '0;
    conf_enable_rr = 1'b0;
    conf_valid     = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_drop();
    test_hash();
    test_rr();
    test_matched();
    test_back_to_back();
    test_wrap_and_conf_race();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
